trap_controller: RTL and testbench
==================================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 The block SHALL have these ports, one clock; reset asynchronous active-low:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- trap_active_i  in  1  writeback-stage exception valid
- trap_cause_i  in  XLEN  exception cause code
- trap_mepc_i  in  XLEN  faulting instruction PC
- mret_i  in  1  writeback-stage MRET valid
- irq_i  in  1  level external interrupt request
- irq_pc_i  in  XLEN  PC of next instruction to retire
- mtvec_i, mepc_i, mstatus_i  in  XLEN each  current CSR values
- csr_we_o  out  1  CSR write strobe
- csr_addr_o  out  12  CSR address
- csr_wdata_o  out  XLEN  CSR write data
- stall_o  out  1  pipeline hold
- flush_o  out  1  one-cycle pipeline flush pulse
- redir_valid_o  out  1  fetch redirect request
- redir_pc_o  out  XLEN  redirect target
- redir_ready_i  in  1  fetch accepts redirect
- busy_o  out  1  FSM not IDLE

Function
REQ-002 FSM states SHALL be IDLE, SAVE_EPC, SAVE_CAUSE, SET_STATUS, RESTORE, REDIRECT.
REQ-003 In IDLE, priority SHALL be: exception > MRET > interrupt (irq_i && mstatus_i[3]).
REQ-004 On accepted exception/interrupt: latch PC (trap_mepc_i or irq_pc_i) and cause (trap_cause_i, or 0x8000000B for interrupt); assert flush_o for that cycle; next state SAVE_EPC.
REQ-005 SAVE_EPC SHALL write latched PC to 0x341, bit 0 forced to 0; -> SAVE_CAUSE.
REQ-006 SAVE_CAUSE SHALL write latched cause to 0x342; -> SET_STATUS.
REQ-007 SET_STATUS SHALL write 0x300 with MPIE(bit7)=old MIE, MIE(bit3)=0, MPP(12:11)=2'b11, other bits from mstatus_i; -> REDIRECT, target = {mtvec_i[XLEN-1:2],2'b00}.
REQ-008 On MRET: flush_o pulse; -> RESTORE; RESTORE SHALL write 0x300 with MIE=old MPIE, MPIE=1; -> REDIRECT, target = mepc_i.
REQ-009 Exactly one CSR write SHALL occur per SAVE_EPC/SAVE_CAUSE/SET_STATUS/RESTORE cycle; csr_we_o=0 in IDLE and REDIRECT.
REQ-010 REDIRECT SHALL hold redir_valid_o=1 with stable redir_pc_o until redir_ready_i=1; on that cycle -> IDLE.
REQ-011 stall_o SHALL be 1 in every non-IDLE state and in the IDLE cycle an event is accepted; busy_o = state != IDLE.
REQ-012 Events arriving while not IDLE SHALL be ignored; pipeline is held so they re-present after return to IDLE.
REQ-013 Trap latency: flush to redir_valid_o SHALL be 4 cycles; MRET latency 2 cycles.
REQ-014 trap_cause_i == all-ones SHALL be treated as no exception.

Reset
REQ-015 While rst_ni=0: state IDLE, all outputs 0, latched PC/cause 0.
REQ-016 Reset mid-sequence SHALL abort immediately; no further CSR write or redirect is issued after release.

Configuration
REQ-017 Macro TRAP_VECTORED_EN: when defined and mtvec_i[1:0]==2'b01 and the cause is an interrupt, target SHALL be base + 4*cause[XLEN-2:0]; otherwise, or when undefined, target is base (direct mode); mtvec_i[1:0] is ignored when undefined.

Structure
REQ-018 State enum, CSR address constants (MSTATUS 0x300, MEPC 0x341, MCAUSE 0x342) and interrupt cause constant SHALL live in tcore_param.
REQ-019 One sub-module, trap_target_calc (combinational mtvec to target computation), is natural; the FSM stays in trap_controller.

Verification
REQ-020 Illegal instruction: trap_cause_i=2, mepc=0x100, mtvec=0x200, redir_ready_i=1 -> writes 0x341=0x100, 0x342=2, 0x300 with MIE=0; redirect to 0x200 at cycle 4.
REQ-021 MRET with mepc=0x104, MPIE=1 -> 0x300 write with MIE=1; redirect to 0x104 after 2 cycles.
REQ-022 Exception, MRET and irq in the same cycle -> exception path only; cause=exception code.
REQ-023 redir_ready_i low for 3 cycles -> redir_valid_o and redir_pc_o held stable; stall_o=1 throughout.
REQ-024 irq_i=1, MIE=0 -> no action; then MIE=1 with TRAP_VECTORED_EN defined and mtvec=0x201 -> mcause=0x8000000B, target 0x22C.
REQ-025 rst_ni low during SAVE_CAUSE -> outputs 0 immediately; no 0x300 write and no redirect after release.

Source files
------------

// File: rtl/tcore_param.sv
// rtl/tcore_param.sv - shared trap-controller constants, state encodings and mstatus helpers
package tcore_param;

    localparam int XLEN = 32;

    typedef logic [2:0] trap_state_t;

    localparam trap_state_t ST_IDLE       = 3'd0;
    localparam trap_state_t ST_SAVE_EPC   = 3'd1;
    localparam trap_state_t ST_SAVE_CAUSE = 3'd2;
    localparam trap_state_t ST_SET_STATUS = 3'd3;
    localparam trap_state_t ST_RESTORE    = 3'd4;
    localparam trap_state_t ST_REDIRECT   = 3'd5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Machine external interrupt: interrupt flag in the MSB, code 11.
    localparam logic [XLEN-1:0] CAUSE_M_EXT_IRQ = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= machine.
    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1.
    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r    = s;
        r[3] = s[7];
        r[7] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_target_calc.sv
// rtl/trap_target_calc.sv - combinational mtvec/cause to trap vector target
//
// Ports:
//   mtvec_i   current mtvec CSR value
//   cause_i   trap cause being taken
//   target_o  fetch redirect target
// Config macro TRAP_VECTORED_EN: enables vectored mode (mtvec[1:0]==2'b01) for
// interrupts; otherwise the target is always the aligned base.
module trap_target_calc
    import tcore_param::*;
(
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] cause_i,
    output logic [XLEN-1:0] target_o
);

    logic [XLEN-1:0] base;
    assign base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    always_comb begin
        target_o = base;
        // 4*cause[XLEN-2:0] truncated to XLEN bits.
        if (mtvec_i[1:0] == 2'b01 && cause_i[XLEN-1]) begin
            target_o = base + {cause_i[XLEN-3:0], 2'b00};
        end
    end
`else
    logic unused_direct;
    assign unused_direct = ^{mtvec_i[1:0], cause_i};
    assign target_o      = base;
`endif

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - trap entry / MRET sequencer driving CSR writes and fetch redirect
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   trap_active_i, trap_cause_i,  writeback exception valid, cause, faulting PC
//   trap_mepc_i
//   mret_i                        writeback MRET valid
//   irq_i, irq_pc_i               level external interrupt, PC of next instruction
//   mtvec_i, mepc_i, mstatus_i    current CSR values
//   csr_we_o, csr_addr_o,         one CSR write per save/restore state
//   csr_wdata_o
//   stall_o, flush_o              pipeline hold, one-cycle flush on acceptance
//   redir_valid_o, redir_pc_o,    fetch redirect handshake
//   redir_ready_i
//   busy_o                        sequencer not idle
// Config macro TRAP_VECTORED_EN: see trap_target_calc.
module trap_controller
    import tcore_param::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            trap_active_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_mepc_i,
    input  logic            mret_i,
    input  logic            irq_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mstatus_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            redir_valid_o,
    output logic [XLEN-1:0] redir_pc_o,
    input  logic            redir_ready_i,
    output logic            busy_o
);

    trap_state_t     state;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] redir_pc_q;
    logic [XLEN-1:0] vec_target;

    logic is_idle;
    logic take_exc;
    logic take_mret;
    logic take_irq;
    logic accept;

    // An all-ones cause marks a bubble, not a real exception. Acceptance is
    // gated with rst_ni so flush/stall are zero while reset is held.
    assign is_idle   = rst_ni && (state == ST_IDLE);
    assign take_exc  = is_idle && trap_active_i && (trap_cause_i != '1);
    assign take_mret = is_idle && !take_exc && mret_i;
    assign take_irq  = is_idle && !take_exc && !mret_i && irq_i && mstatus_i[3];
    assign accept    = take_exc || take_mret || take_irq;

    trap_target_calc u_target_calc (
        .mtvec_i  (mtvec_i),
        .cause_i  (cause_q),
        .target_o (vec_target)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            epc_q      <= '0;
            cause_q    <= '0;
            redir_pc_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_exc) begin
                        epc_q   <= trap_mepc_i;
                        cause_q <= trap_cause_i;
                        state   <= ST_SAVE_EPC;
                    end else if (take_mret) begin
                        state   <= ST_RESTORE;
                    end else if (take_irq) begin
                        epc_q   <= irq_pc_i;
                        cause_q <= CAUSE_M_EXT_IRQ;
                        state   <= ST_SAVE_EPC;
                    end
                end
                ST_SAVE_EPC:   state <= ST_SAVE_CAUSE;
                ST_SAVE_CAUSE: state <= ST_SET_STATUS;
                // Target is captured on entry to REDIRECT so it stays stable
                // even if mtvec/mepc change while fetch is back-pressuring.
                ST_SET_STATUS: begin
                    redir_pc_q <= vec_target;
                    state      <= ST_REDIRECT;
                end
                ST_RESTORE: begin
                    redir_pc_q <= mepc_i;
                    state      <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    if (redir_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        csr_we_o      = 1'b0;
        csr_addr_o    = 12'h000;
        csr_wdata_o   = '0;
        stall_o       = 1'b0;
        flush_o       = 1'b0;
        redir_valid_o = 1'b0;
        redir_pc_o    = '0;
        case (state)
            ST_IDLE: begin
                stall_o = accept;
                flush_o = accept;
            end
            ST_SAVE_EPC: begin
                stall_o     = 1'b1;
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MEPC;
                csr_wdata_o = {epc_q[XLEN-1:1], 1'b0};
            end
            ST_SAVE_CAUSE: begin
                stall_o     = 1'b1;
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            ST_SET_STATUS: begin
                stall_o     = 1'b1;
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = mstatus_on_trap(mstatus_i);
            end
            ST_RESTORE: begin
                stall_o     = 1'b1;
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = mstatus_on_mret(mstatus_i);
            end
            ST_REDIRECT: begin
                stall_o       = 1'b1;
                redir_valid_o = 1'b1;
                redir_pc_o    = redir_pc_q;
            end
            default: stall_o = 1'b1;
        endcase
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - self-checking bench for trap_controller
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_active;
    logic [31:0] trap_cause;
    logic [31:0] trap_mepc;
    logic        mret;
    logic        irq;
    logic [31:0] irq_pc;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mstatus;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    trap_controller dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .trap_active_i (trap_active),
        .trap_cause_i  (trap_cause),
        .trap_mepc_i   (trap_mepc),
        .mret_i        (mret),
        .irq_i         (irq),
        .irq_pc_i      (irq_pc),
        .mtvec_i       (mtvec),
        .mepc_i        (mepc),
        .mstatus_i     (mstatus),
        .csr_we_o      (csr_we),
        .csr_addr_o    (csr_addr),
        .csr_wdata_o   (csr_wdata),
        .stall_o       (stall),
        .flush_o       (flush),
        .redir_valid_o (redir_valid),
        .redir_pc_o    (redir_pc),
        .redir_ready_i (redir_ready),
        .busy_o        (busy)
    );

    typedef struct {
        string       name;
        logic        t_act;
        logic [31:0] t_cause;
        logic [31:0] t_mepc;
        logic        t_mret;
        logic        t_irq;
        logic [31:0] t_irq_pc;
        logic [31:0] t_mtvec;
        logic [31:0] t_mepc_csr;
        logic [31:0] t_mstatus;
        int          kind;      // 0 none, 1 trap, 2 mret
        logic [31:0] e_epc;
        logic [31:0] e_cause;
        logic [31:0] e_status;
        logic [31:0] e_target;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_events();
        trap_active = 1'b0;
        trap_cause  = 32'h0;
        mret        = 1'b0;
        irq         = 1'b0;
    endtask

    task automatic expect_write(input string name, input logic [11:0] addr, input logic [31:0] data);
        check({name, " we"},    {31'b0, csr_we}, 32'd1);
        check({name, " addr"},  {20'b0, csr_addr}, {20'b0, addr});
        check({name, " wdata"}, csr_wdata, data);
        check({name, " stall"}, {31'b0, stall}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        trap_active = v.t_act;   trap_cause = v.t_cause; trap_mepc = v.t_mepc;
        mret        = v.t_mret;  irq        = v.t_irq;   irq_pc    = v.t_irq_pc;
        mtvec       = v.t_mtvec; mepc       = v.t_mepc_csr;
        mstatus     = v.t_mstatus;
        redir_ready = 1'b1;
        #1;
        check({v.name, " flush"}, {31'b0, flush}, (v.kind != 0) ? 32'd1 : 32'd0);
        check({v.name, " stall0"}, {31'b0, stall}, (v.kind != 0) ? 32'd1 : 32'd0);
        check({v.name, " we0"}, {31'b0, csr_we}, 32'd0);
        step();
        clear_events();
        #1;
        if (v.kind == 1) begin
            expect_write({v.name, " mepc"}, 12'h341, v.e_epc);
            step();
            expect_write({v.name, " mcause"}, 12'h342, v.e_cause);
            step();
            expect_write({v.name, " mstatus"}, 12'h300, v.e_status);
            step();
        end else if (v.kind == 2) begin
            expect_write({v.name, " restore"}, 12'h300, v.e_status);
            step();
        end
        if (v.kind != 0) begin
            check({v.name, " redir_valid"}, {31'b0, redir_valid}, 32'd1);
            check({v.name, " redir_pc"}, redir_pc, v.e_target);
            check({v.name, " we_redir"}, {31'b0, csr_we}, 32'd0);
            step();
        end
        check({v.name, " busy_end"}, {31'b0, busy}, 32'd0);
        check({v.name, " valid_end"}, {31'b0, redir_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] irq_target;
`ifdef TRAP_VECTORED_EN
        irq_target = 32'h0000_022C;
`else
        irq_target = 32'h0000_0200;
`endif
        vecs[0] = '{"illegal", 1'b1, 32'd2, 32'h100, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h8,
                    1, 32'h100, 32'd2, 32'h1880, 32'h200};
        vecs[1] = '{"mret", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h104, 32'h80,
                    2, 32'h0, 32'h0, 32'h88, 32'h104};
        vecs[2] = '{"prio_all", 1'b1, 32'd5, 32'h301, 1'b1, 1'b1, 32'h777, 32'h400, 32'h900, 32'h8,
                    1, 32'h300, 32'd5, 32'h1880, 32'h400};
        vecs[3] = '{"cause_ones", 1'b1, 32'hFFFF_FFFF, 32'h100, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h8,
                    0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[4] = '{"ones_mret", 1'b1, 32'hFFFF_FFFF, 32'h100, 1'b1, 1'b0, 32'h0, 32'h200, 32'h2000, 32'h0,
                    2, 32'h0, 32'h0, 32'h80, 32'h2000};
        vecs[5] = '{"irq_masked", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h555, 32'h201, 32'h0, 32'h80,
                    0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6] = '{"irq_taken", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h555, 32'h201, 32'h0, 32'h8,
                    1, 32'h554, 32'h8000_000B, 32'h1880, irq_target};
        vecs[7] = '{"exc_vecmode", 1'b1, 32'd3, 32'h40, 1'b0, 1'b0, 32'h0, 32'h201, 32'h0, 32'hFFFF_FFF7,
                    1, 32'h40, 32'd3, 32'hFFFF_FF77, 32'h200};
        vecs[8] = '{"mret_mpie0", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h8000_0000, 32'hFFFF_FF77,
                    2, 32'h0, 32'h0, 32'hFFFF_FFF7, 32'h8000_0000};

        // Reset state, with events presented so acceptance gating is exercised.
        rst_n = 1'b0; trap_active = 1'b1; trap_cause = 32'd2; trap_mepc = 32'h100;
        mret = 1'b1; irq = 1'b1; irq_pc = 32'h0; mtvec = 32'h200; mepc = 32'h104;
        mstatus = 32'h8; redir_ready = 1'b1;
        step();
        check("rst flush", {31'b0, flush}, 32'd0);
        check("rst stall", {31'b0, stall}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst we", {31'b0, csr_we}, 32'd0);
        check("rst valid", {31'b0, redir_valid}, 32'd0);
        check("rst outs", {8'b0, csr_addr, redir_pc[11:0]} | csr_wdata | redir_pc, 32'd0);
        clear_events();
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-pressure: redirect held three cycles; new events ignored while busy.
        trap_active = 1'b1; trap_cause = 32'd2; trap_mepc = 32'h100;
        mtvec = 32'h200; mstatus = 32'h8; redir_ready = 1'b0;
        step();
        clear_events();
        step(); step(); step();
        mtvec = 32'h0000_0F00;
        irq = 1'b1; trap_active = 1'b1; trap_cause = 32'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold valid c%0d", c), {31'b0, redir_valid}, 32'd1);
            check($sformatf("hold pc c%0d", c), redir_pc, 32'h200);
            check($sformatf("hold stall c%0d", c), {31'b0, stall}, 32'd1);
            check($sformatf("hold flush c%0d", c), {31'b0, flush}, 32'd0);
            step();
        end
        clear_events();
        redir_ready = 1'b1;
        step();
        check("hold done busy", {31'b0, busy}, 32'd0);

        // Reset during SAVE_CAUSE aborts the sequence.
        trap_active = 1'b1; trap_cause = 32'd2; trap_mepc = 32'h100; mtvec = 32'h200;
        step();
        clear_events();
        step();
        check("abort in cause", {20'b0, csr_addr}, 32'h342);
        rst_n = 1'b0;
        #1;
        check("abort we", {31'b0, csr_we}, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort stall", {31'b0, stall}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("post abort c%0d", c), {30'b0, csr_we, redir_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
